// File: rtl/rf_wb_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | rf_wb_arbiter: register-file writeback arbiter with a 2-entry B queue,   |
// | starvation-bounded priority and a busy-bit RAW scoreboard.               |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module rf_wb_arbiter #(
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        a_valid,
  input  logic [4:0]  a_wr,
  input  logic [31:0] a_data,
  output logic        a_stall,
  input  logic        b_valid,
  input  logic [4:0]  b_wr,
  input  logic [31:0] b_data,
  output logic        b_ready,
  input  logic        iss_valid,
  input  logic [4:0]  iss_wr,
  input  logic [4:0]  rR1,
  input  logic [4:0]  rR2,
  output logic        hz,
  output logic        rf_we,
  output logic [4:0]  WR,
  output logic [31:0] WD,
  output logic [1:0]  q_cnt
);

  localparam int            SW           = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] C_STARVE_MAX = SW'(STARVE_MAX);

  logic [4:0]    e0_wr_q, e0_wr_d, e1_wr_q, e1_wr_d;
  logic [31:0]   e0_data_q, e0_data_d, e1_data_q, e1_data_d;
  logic [1:0]    cnt_q, cnt_d;
  logic [SW-1:0] starve_q, starve_d;
  logic [31:0]   busy_q, busy_d;
  logic          grant_a, grant_b, push;

  always_comb begin
    grant_b = (cnt_q != 2'd0) && (!a_valid || (starve_q == C_STARVE_MAX));
    grant_a = a_valid && !grant_b;
    // Readiness comes from registered occupancy only, so a full queue never accepts on a pop cycle.
    b_ready = rst && (cnt_q != 2'd2);
    push    = b_valid && b_ready;
    a_stall = rst && a_valid && grant_b;
    hz      = rst && (busy_q[rR1] | busy_q[rR2]);
    q_cnt   = cnt_q;
    rf_we   = 1'b0;
    WR      = 5'd0;
    WD      = 32'd0;
    if (rst) begin
      if (grant_b) begin
        rf_we = (e0_wr_q != 5'd0);
        WR    = e0_wr_q;
        WD    = e0_data_q;
      end else if (grant_a) begin
        rf_we = (a_wr != 5'd0);
        WR    = a_wr;
        WD    = a_data;
      end
    end
  end

  always_comb begin
    e0_wr_d   = e0_wr_q;
    e0_data_d = e0_data_q;
    e1_wr_d   = e1_wr_q;
    e1_data_d = e1_data_q;
    cnt_d     = cnt_q;
    case (cnt_q)
      2'd0: begin
        if (push) begin
          e0_wr_d   = b_wr;
          e0_data_d = b_data;
          cnt_d     = 2'd1;
        end
      end
      2'd1: begin
        if (push && grant_b) begin
          e0_wr_d   = b_wr;
          e0_data_d = b_data;
        end else if (push) begin
          e1_wr_d   = b_wr;
          e1_data_d = b_data;
          cnt_d     = 2'd2;
        end else if (grant_b) begin
          cnt_d = 2'd0;
        end
      end
      2'd2: begin
        if (grant_b) begin
          e0_wr_d   = e1_wr_q;
          e0_data_d = e1_data_q;
          cnt_d     = 2'd1;
        end
      end
      default: cnt_d = 2'd0;
    endcase

    starve_d = starve_q;
    if ((cnt_q == 2'd0) || grant_b) begin
      starve_d = '0;
    end else if (starve_q != C_STARVE_MAX) begin
      starve_d = starve_q + SW'(1);
    end

    // Clear before set so a same-cycle reissue keeps the register busy.
    busy_d = busy_q;
    if (grant_b) begin
      busy_d[e0_wr_q] = 1'b0;
    end
    if (iss_valid && (iss_wr != 5'd0)) begin
      busy_d[iss_wr] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      e0_wr_q   <= 5'd0;
      e0_data_q <= 32'd0;
      e1_wr_q   <= 5'd0;
      e1_data_q <= 32'd0;
      cnt_q     <= 2'd0;
      starve_q  <= '0;
      busy_q    <= 32'd0;
    end else begin
      e0_wr_q   <= e0_wr_d;
      e0_data_q <= e0_data_d;
      e1_wr_q   <= e1_wr_d;
      e1_data_q <= e1_data_d;
      cnt_q     <= cnt_d;
      starve_q  <= starve_d;
      busy_q    <= busy_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rf_wb_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_rf_wb_arbiter: vector table, reset sequence and randomized run        |
// | against a queue-based reference model.                                   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_rf_wb_arbiter;
  localparam int STARVE_MAX = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        a_valid, b_valid, iss_valid;
  logic [4:0]  a_wr, b_wr, iss_wr, rR1, rR2;
  logic [31:0] a_data, b_data;
  logic        a_stall, b_ready, hz, rf_we;
  logic [4:0]  WR;
  logic [31:0] WD;
  logic [1:0]  q_cnt;

  rf_wb_arbiter #(.STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_wr(a_wr), .a_data(a_data), .a_stall(a_stall),
    .b_valid(b_valid), .b_wr(b_wr), .b_data(b_data), .b_ready(b_ready),
    .iss_valid(iss_valid), .iss_wr(iss_wr), .rR1(rR1), .rR2(rR2), .hz(hz),
    .rf_we(rf_we), .WR(WR), .WD(WD), .q_cnt(q_cnt)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: B results held in an SV queue, scoreboard as a bit array.
  typedef struct {
    logic [4:0]  wr;
    logic [31:0] d;
  } ent_t;
  ent_t mq[$];
  bit   mbusy[32];
  int   mstarve;
  bit   m_gb, m_push;
  logic        e_we, e_stall, e_br, e_hz;
  logic [4:0]  e_wr;
  logic [31:0] e_wd;
  logic [1:0]  e_qc;

  task automatic model_eval();
    bit ga;
    if (!rst) begin
      mq.delete();
      foreach (mbusy[i]) mbusy[i] = 1'b0;
      mstarve = 0;
    end
    e_br   = rst && (mq.size() != 2);
    m_gb   = rst && (mq.size() != 0) && (!a_valid || (mstarve == STARVE_MAX));
    ga     = rst && a_valid && !m_gb;
    m_push = rst && b_valid && e_br;
    e_we = 1'b0; e_wr = 5'd0; e_wd = 32'd0;
    if (m_gb) begin
      e_wr = mq[0].wr; e_wd = mq[0].d; e_we = (mq[0].wr != 5'd0);
    end else if (ga) begin
      e_wr = a_wr; e_wd = a_data; e_we = (a_wr != 5'd0);
    end
    e_stall = rst && a_valid && m_gb;
    e_hz    = rst && (mbusy[rR1] || mbusy[rR2]);
    e_qc    = 2'(mq.size());
  endtask

  task automatic model_update();
    int sz;
    ent_t ne;
    if (!rst) return;
    sz = mq.size();
    if (m_gb) begin
      mbusy[mq[0].wr] = 1'b0;
      void'(mq.pop_front());
    end
    if (m_push) begin
      ne.wr = b_wr; ne.d = b_data;
      mq.push_back(ne);
    end
    if (sz == 0 || m_gb) mstarve = 0;
    else if (mstarve < STARVE_MAX) mstarve = mstarve + 1;
    if (iss_valid && iss_wr != 5'd0) mbusy[iss_wr] = 1'b1;
  endtask

  task automatic cmp_model();
    chk("rf_we", {31'd0, rf_we}, {31'd0, e_we});
    chk("WR", {27'd0, WR}, {27'd0, e_wr});
    chk("WD", WD, e_wd);
    chk("a_stall", {31'd0, a_stall}, {31'd0, e_stall});
    chk("b_ready", {31'd0, b_ready}, {31'd0, e_br});
    chk("hz", {31'd0, hz}, {31'd0, e_hz});
    chk("q_cnt", {30'd0, q_cnt}, {30'd0, e_qc});
  endtask

  task automatic settle();
    #1;
    model_eval();
  endtask

  task automatic advance();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic drive(input int av, input int awr, input int ad, input int bv, input int bwr,
                       input int bd, input int iv, input int iwr, input int r1, input int r2);
    a_valid = 1'(av); a_wr = 5'(awr); a_data = 32'(ad);
    b_valid = 1'(bv); b_wr = 5'(bwr); b_data = 32'(bd);
    iss_valid = 1'(iv); iss_wr = 5'(iwr); rR1 = 5'(r1); rR2 = 5'(r2);
  endtask

  typedef struct {
    int av, awr, ad, bv, bwr, bd, iv, iwr, r1, r2;
    int we, wr, wd, st, br, hz, qc;
  } vec_t;
  localparam int NV = 27;
  vec_t tv[NV];

  function automatic vec_t mk(int av, int awr, int ad, int bv, int bwr, int bd, int iv, int iwr,
                              int r1, int r2, int we, int wr, int wd, int st, int br, int h, int qc);
    vec_t v;
    v.av = av; v.awr = awr; v.ad = ad; v.bv = bv; v.bwr = bwr; v.bd = bd;
    v.iv = iv; v.iwr = iwr; v.r1 = r1; v.r2 = r2;
    v.we = we; v.wr = wr; v.wd = wd; v.st = st; v.br = br; v.hz = h; v.qc = qc;
    return v;
  endfunction

  initial begin
    //              av awr ad      bv bwr bd     iv iwr r1 r2 | we wr wd     st br hz qc
    tv[0]  = mk(1, 5, 'h11,  0, 0, 0,     0, 0, 0, 0,  1, 5, 'h11,  0, 1, 0, 0);
    tv[1]  = mk(1, 6, 'h22,  1, 7, 'hAA,  0, 0, 0, 0,  1, 6, 'h22,  0, 1, 0, 0);
    tv[2]  = mk(1, 1, 'h01,  0, 0, 0,     0, 0, 0, 0,  1, 1, 'h01,  0, 1, 0, 1);
    tv[3]  = mk(1, 2, 'h02,  0, 0, 0,     0, 0, 0, 0,  1, 2, 'h02,  0, 1, 0, 1);
    tv[4]  = mk(1, 3, 'h03,  0, 0, 0,     0, 0, 0, 0,  1, 3, 'h03,  0, 1, 0, 1);
    tv[5]  = mk(1, 4, 'h04,  0, 0, 0,     0, 0, 0, 0,  1, 4, 'h04,  0, 1, 0, 1);
    tv[6]  = mk(1, 5, 'h05,  0, 0, 0,     0, 0, 0, 0,  1, 7, 'hAA,  1, 1, 0, 1);
    tv[7]  = mk(1, 5, 'h05,  0, 0, 0,     0, 0, 0, 0,  1, 5, 'h05,  0, 1, 0, 0);
    tv[8]  = mk(1, 10,'h100, 1, 8, 'h80,  0, 0, 0, 0,  1, 10,'h100, 0, 1, 0, 0);
    tv[9]  = mk(1, 11,'h101, 1, 9, 'h90,  0, 0, 0, 0,  1, 11,'h101, 0, 1, 0, 1);
    tv[10] = mk(0, 0, 0,     1, 12,'hC0,  0, 0, 0, 0,  1, 8, 'h80,  0, 0, 0, 2);
    tv[11] = mk(0, 0, 0,     1, 12,'hC0,  0, 0, 0, 0,  1, 9, 'h90,  0, 1, 0, 1);
    tv[12] = mk(0, 0, 0,     0, 0, 0,     0, 0, 0, 0,  1, 12,'hC0,  0, 1, 0, 1);
    tv[13] = mk(0, 0, 0,     0, 0, 0,     0, 0, 0, 0,  0, 0, 0,     0, 1, 0, 0);
    tv[14] = mk(1, 0, 'h55,  0, 0, 0,     0, 0, 0, 0,  0, 0, 'h55,  0, 1, 0, 0);
    tv[15] = mk(0, 0, 0,     0, 0, 0,     1, 9, 9, 0,  0, 0, 0,     0, 1, 0, 0);
    tv[16] = mk(0, 0, 0,     0, 0, 0,     0, 0, 9, 0,  0, 0, 0,     0, 1, 1, 0);
    tv[17] = mk(0, 0, 0,     0, 0, 0,     1, 0, 9, 0,  0, 0, 0,     0, 1, 1, 0);
    tv[18] = mk(0, 0, 0,     1, 9, 'h99,  0, 0, 9, 0,  0, 0, 0,     0, 1, 1, 0);
    tv[19] = mk(0, 0, 0,     0, 0, 0,     1, 9, 9, 0,  1, 9, 'h99,  0, 1, 1, 1);
    tv[20] = mk(0, 0, 0,     0, 0, 0,     0, 0, 9, 0,  0, 0, 0,     0, 1, 1, 0);
    tv[21] = mk(0, 0, 0,     1, 9, 'h77,  0, 0, 9, 0,  0, 0, 0,     0, 1, 1, 0);
    tv[22] = mk(0, 0, 0,     0, 0, 0,     0, 0, 9, 0,  1, 9, 'h77,  0, 1, 1, 1);
    tv[23] = mk(0, 0, 0,     0, 0, 0,     0, 0, 9, 0,  0, 0, 0,     0, 1, 0, 0);
    tv[24] = mk(0, 0, 0,     0, 0, 0,     1, 0, 0, 0,  0, 0, 0,     0, 1, 0, 0);
    tv[25] = mk(0, 0, 0,     1, 0, 'h33,  0, 0, 0, 0,  0, 0, 0,     0, 1, 0, 0);
    tv[26] = mk(0, 0, 0,     0, 0, 0,     0, 0, 0, 0,  0, 0, 'h33,  0, 1, 0, 1);

    rst = 1'b0;
    drive(1, 3, 'h5A, 1, 4, 'h6B, 1, 3, 3, 4);
    @(negedge clk);
    settle();
    chk("rst_rf_we", {31'd0, rf_we}, 32'd0);
    chk("rst_b_ready", {31'd0, b_ready}, 32'd0);
    chk("rst_a_stall", {31'd0, a_stall}, 32'd0);
    chk("rst_WR", {27'd0, WR}, 32'd0);
    chk("rst_q_cnt", {30'd0, q_cnt}, 32'd0);
    advance();
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    advance();

    for (int i = 0; i < NV; i++) begin
      drive(tv[i].av, tv[i].awr, tv[i].ad, tv[i].bv, tv[i].bwr, tv[i].bd,
            tv[i].iv, tv[i].iwr, tv[i].r1, tv[i].r2);
      settle();
      chk($sformatf("v%0d_rf_we", i), {31'd0, rf_we}, 32'(tv[i].we));
      chk($sformatf("v%0d_WR", i), {27'd0, WR}, 32'(tv[i].wr));
      chk($sformatf("v%0d_WD", i), WD, 32'(tv[i].wd));
      chk($sformatf("v%0d_a_stall", i), {31'd0, a_stall}, 32'(tv[i].st));
      chk($sformatf("v%0d_b_ready", i), {31'd0, b_ready}, 32'(tv[i].br));
      chk($sformatf("v%0d_hz", i), {31'd0, hz}, 32'(tv[i].hz));
      chk($sformatf("v%0d_q_cnt", i), {30'd0, q_cnt}, 32'(tv[i].qc));
      advance();
    end

    // Fill the queue and the scoreboard, then reset mid-operation.
    drive(1, 3, 'h31, 1, 3, 'h3, 1, 3, 0, 0);
    settle(); cmp_model(); advance();
    drive(1, 4, 'h41, 1, 4, 'h4, 0, 0, 0, 0);
    settle(); cmp_model(); advance();
    drive(1, 5, 'h51, 1, 5, 'h5, 1, 5, 3, 4);
    settle();
    chk("pre_rst_q_cnt", {30'd0, q_cnt}, 32'd2);
    chk("pre_rst_hz", {31'd0, hz}, 32'd1);
    rst = 1'b0;
    settle();
    chk("mid_rst_q_cnt", {30'd0, q_cnt}, 32'd0);
    chk("mid_rst_hz", {31'd0, hz}, 32'd0);
    chk("mid_rst_rf_we", {31'd0, rf_we}, 32'd0);
    chk("mid_rst_WD", WD, 32'd0);
    chk("mid_rst_b_ready", {31'd0, b_ready}, 32'd0);
    advance();
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 3, 4);
    for (int k = 0; k < 3; k++) begin
      settle();
      chk("post_rst_rf_we", {31'd0, rf_we}, 32'd0);
      chk("post_rst_q_cnt", {30'd0, q_cnt}, 32'd0);
      chk("post_rst_hz", {31'd0, hz}, 32'd0);
      chk("post_rst_b_ready", {31'd0, b_ready}, 32'd1);
      advance();
    end

    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 199) != 0);
      drive(($urandom_range(0, 3) != 0) ? 1 : 0, int'($urandom_range(0, 31)), int'($urandom()),
            int'($urandom_range(0, 1)), int'($urandom_range(0, 31)), int'($urandom()),
            ($urandom_range(0, 3) == 0) ? 1 : 0, int'($urandom_range(0, 31)),
            int'($urandom_range(0, 31)), int'($urandom_range(0, 31)));
      settle();
      cmp_model();
      advance();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rf_wb_arbiter.md
RF_WB_ARBITER -- requirements
Module: rf_wb_arbiter

Interface
REQ-001 Parameter STARVE_MAX, default 4: max consecutive cycles a non-empty B queue waits before forced grant.
REQ-002 Port clk  in  1  sole clock; all state updates on posedge.
REQ-003 Port rst  in  1  asynchronous active-low reset.
REQ-004 Port a_valid  in  1  primary pipeline writeback request.
REQ-005 Port a_wr  in  5  primary destination register.
REQ-006 Port a_data  in  32  primary writeback data.
REQ-007 Port a_stall  out  1  primary request not accepted this cycle; requester holds a_* stable.
REQ-008 Port b_valid  in  1  long-latency unit result valid.
REQ-009 Port b_wr  in  5  long-latency destination register.
REQ-010 Port b_data  in  32  long-latency result data.
REQ-011 Port b_ready  out  1  B queue can accept; transfer when b_valid && b_ready.
REQ-012 Port iss_valid  in  1  long-latency op issued this cycle.
REQ-013 Port iss_wr  in  5  destination of issued op.
REQ-014 Port rR1  in  5  decode-stage source register 1.
REQ-015 Port rR2  in  5  decode-stage source register 2.
REQ-016 Port hz  out  1  RAW hazard on rR1 or rR2; decode stalls.
REQ-017 Port rf_we  out  1  register file write enable.
REQ-018 Port WR  out  5  register file write address.
REQ-019 Port WD  out  32  register file write data.
REQ-020 Port q_cnt  out  2  B queue occupancy, 0..2.

Function
REQ-021 B queue SHALL be a 2-entry FIFO; b_ready = (q_cnt != 2), decided from registered state only; push on b_valid && b_ready.
REQ-022 Full queue SHALL hold b_ready low for the whole cycle even if a pop occurs that cycle (no same-cycle push-on-pop when full).
REQ-023 Grant B (pop head) SHALL occur when q_cnt != 0 and (!a_valid or starve_cnt == STARVE_MAX); else grant A if a_valid; else no grant.
REQ-024 a_stall SHALL equal a_valid && grant B, combinational.
REQ-025 starve_cnt SHALL increment when q_cnt != 0 and B not granted, saturate at STARVE_MAX, clear on B grant or when q_cnt == 0.
REQ-026 Granted request SHALL drive WR/WD combinationally in the same cycle; RF captures at the next posedge.
REQ-027 rf_we SHALL be 1 only for a grant whose destination != 0; a grant to x0 is consumed (popped/accepted) with rf_we = 0.
REQ-028 No grant: rf_we = 0, WR = 0, WD = 0.
REQ-029 Simultaneous push and pop with q_cnt == 1 SHALL leave q_cnt == 1 with the new entry at head.
REQ-030 Scoreboard: 32 busy bits; iss_valid with iss_wr != 0 sets busy[iss_wr] at posedge.
REQ-031 B grant to register r SHALL clear busy[r] at posedge; A grants SHALL NOT change busy.
REQ-032 Same-cycle set and clear of the same register: set wins.
REQ-033 hz = busy[rR1] | busy[rR2], combinational; busy[0] always 0.
REQ-034 Issue to an already-busy register SHALL leave it busy (single bit, no count).

Reset
REQ-035 rst low SHALL immediately clear queue, q_cnt, starve_cnt, all busy bits.
REQ-036 While rst low: rf_we = 0, a_stall = 0, b_ready = 0, hz = 0, WR = 0, WD = 0, regardless of inputs.
REQ-037 Reset asserted mid-operation SHALL discard queued B results; first accept possible on first posedge after rst rises.

Verification
REQ-038 a_valid=1 a_wr=5 a_data=0x11, queue empty -> rf_we=1 WR=5 WD=0x11, a_stall=0.
REQ-039 Push B (wr=7,data=0xAA) while a_valid held 1 every cycle, STARVE_MAX=4 -> B waits 4 cycles, 5th cycle rf_we=1 WR=7 WD=0xAA, a_stall=1 that cycle only.
REQ-040 Push three B results back-to-back, a_valid=0 -> b_ready low when q_cnt=2, in-order writes, q_cnt returns to 0.
REQ-041 iss_valid iss_wr=9, then rR1=9 -> hz=1 until B write to 9 granted, hz=0 the cycle after; iss_wr=0 -> hz never 1.
REQ-042 B grant to 9 coincident with iss_valid iss_wr=9 -> busy[9] stays 1.
REQ-043 Assert rst with q_cnt=2 and busy bits set -> q_cnt=0, hz=0, rf_we=0 immediately, no stale writes after release.
